// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: bundles the requester command/response channels and the
// APB master signals of apb_master_bridge. Modport "master" is the bridge view;
// modport "slave" is the opposite side, i.e. the requester plus the APB slave.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8
);
  // requester command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_write;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [2:0]            cmd_prot;
  // requester response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  // APB bus
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [2:0]            PPROT;
  logic                  PNSE;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_prot, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_prot, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns one valid/ready command at a time into an APB
// SETUP/ACCESS transfer and returns the captured result on a valid/ready
// response channel. All APB outputs come straight from registers.
// Optional macro APB_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYCLES
// cycles without PREADY and report it as an error response.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_master_bridge_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // state and every bus/response output register; async reset clears all
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pprot_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // next-state and next register values; everything holds unless a phase moves it
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pprot_d  = bus.cmd_prot;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          // expiry is judged on the incremented count so the abort lands on
          // the TIMEOUT_CYCLES-th stalled edge; PREADY=1 there completes normally
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            state_d     = RESP;
          end
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PPROT     = pprot_q;
  assign bus.PNSE      = 1'b0;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of apb_master_bridge; the bench plays
// both the requester and the APB slave.
module tb_apb_master_bridge;

  logic PCLK;
  logic PRESETn;
  int   checks;
  int   errors;

  apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic w, input logic [7:0] d, input logic [2:0] p);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_write = w;
    bus.cmd_wdata = d;
    bus.cmd_prot  = p;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    PRESETn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    // reset values
    tick();
    tick();
    chk("rst_psel", bus.PSEL, 1'b0);
    chk("rst_penable", bus.PENABLE, 1'b0);
    chk("rst_pwrite", bus.PWRITE, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pprot", bus.PPROT, 3'b000);
    chk("rst_pwdata", bus.PWDATA, 8'h00);
    chk("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    chk("rst_pnse", bus.PNSE, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    PRESETn = 1'b1;
    tick();

    // write, zero wait states
    send(32'h0000_0008, 1'b1, 8'hA5, 3'b010);
    bus.PREADY = 1'b1;
    chk("wr_cmd_ready_idle", bus.cmd_ready, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("wr_setup_psel", bus.PSEL, 1'b1);
    chk("wr_setup_penable", bus.PENABLE, 1'b0);
    chk("wr_setup_paddr", bus.PADDR, 32'h8);
    chk("wr_setup_pwdata", bus.PWDATA, 8'hA5);
    chk("wr_setup_pprot", bus.PPROT, 3'b010);
    chk("wr_setup_pwrite", bus.PWRITE, 1'b1);
    chk("wr_setup_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    chk("wr_acc_psel", bus.PSEL, 1'b1);
    chk("wr_acc_penable", bus.PENABLE, 1'b1);
    chk("wr_acc_paddr", bus.PADDR, 32'h8);
    chk("wr_acc_pwdata", bus.PWDATA, 8'hA5);
    chk("wr_acc_pprot", bus.PPROT, 3'b010);
    tick();
    chk("wr_done_psel", bus.PSEL, 1'b0);
    chk("wr_done_penable", bus.PENABLE, 1'b0);
    chk("wr_done_rsp_valid", bus.rsp_valid, 1'b1);
    chk("wr_done_rsp_err", bus.rsp_err, 1'b0);
    chk("wr_done_rsp_rdata", bus.rsp_rdata, 8'h00);
    bus.PREADY = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("wr_rsp_taken", bus.rsp_valid, 1'b0);
    chk("wr_back_idle", bus.cmd_ready, 1'b1);
    bus.rsp_ready = 1'b0;

    // read with one wait state; PRDATA/PSLVERR noise while PREADY=0 is ignored
    send(32'h0000_0008, 1'b0, 8'hFF, 3'b000);
    bus.PRDATA  = 8'h5A;
    bus.PSLVERR = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rd_setup_pwrite", bus.PWRITE, 1'b0);
    chk("rd_setup_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    chk("rd_acc1_penable", bus.PENABLE, 1'b1);
    chk("rd_acc1_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    chk("rd_acc2_penable", bus.PENABLE, 1'b1);
    chk("rd_acc2_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rd_acc2_cmd_ready", bus.cmd_ready, 1'b0);
    bus.PREADY  = 1'b1;
    bus.PRDATA  = 8'hA5;
    bus.PSLVERR = 1'b0;
    tick();
    chk("rd_done_penable", bus.PENABLE, 1'b0);
    chk("rd_done_rsp_valid", bus.rsp_valid, 1'b1);
    chk("rd_done_rsp_rdata", bus.rsp_rdata, 8'hA5);
    chk("rd_done_rsp_err", bus.rsp_err, 1'b0);
    bus.PREADY = 1'b0;
    bus.PRDATA = 8'h00;

    // response backpressure with a pending command
    send(32'h0000_0020, 1'b1, 8'h3C, 3'b001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 8'hA5);
      chk("bp_cmd_ready", bus.cmd_ready, 1'b0);
      chk("bp_psel", bus.PSEL, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_released_rsp_valid", bus.rsp_valid, 1'b0);
    chk("bp_released_cmd_ready", bus.cmd_ready, 1'b1);
    chk("bp_released_psel", bus.PSEL, 1'b0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bp_next_psel", bus.PSEL, 1'b1);
    chk("bp_next_paddr", bus.PADDR, 32'h20);
    chk("bp_next_pwdata", bus.PWDATA, 8'h3C);
    bus.PREADY  = 1'b1;
    bus.PRDATA  = 8'hEE;
    tick();
    tick();
    chk("bp_next_rsp_valid", bus.rsp_valid, 1'b1);
    chk("bp_next_rsp_rdata", bus.rsp_rdata, 8'h00);
    bus.PREADY = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // slave error, then a clean read clears rsp_err
    send(32'h0000_0010, 1'b0, 8'h00, 3'b000);
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 8'h77;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    chk("err_rsp_valid", bus.rsp_valid, 1'b1);
    chk("err_rsp_err", bus.rsp_err, 1'b1);
    chk("err_rsp_rdata", bus.rsp_rdata, 8'h77);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    send(32'h0000_0004, 1'b0, 8'h00, 3'b000);
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 8'h12;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    chk("err_next_rsp_err", bus.rsp_err, 1'b0);
    chk("err_next_rsp_rdata", bus.rsp_rdata, 8'h12);
    bus.PREADY = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // reset in the middle of ACCESS
    send(32'h0000_0030, 1'b1, 8'h99, 3'b100);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("mid_rst_penable_before", bus.PENABLE, 1'b1);
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", bus.PSEL, 1'b0);
    chk("mid_rst_penable", bus.PENABLE, 1'b0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_paddr", bus.PADDR, 32'h0);
    tick();
    PRESETn = 1'b1;
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
    send(32'h0000_002C, 1'b0, 8'h00, 3'b011);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h99;
    tick();
    bus.cmd_valid = 1'b0;
    chk("post_rst_psel", bus.PSEL, 1'b1);
    tick();
    tick();
    chk("post_rst_rsp_valid", bus.rsp_valid, 1'b1);
    chk("post_rst_rsp_rdata", bus.rsp_rdata, 8'h99);
    chk("post_rst_rsp_err", bus.rsp_err, 1'b0);
    bus.PREADY = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

`ifdef APB_TIMEOUT_EN
    // PREADY never comes: abort on the 16th stalled ACCESS edge
    send(32'h0000_0040, 1'b0, 8'h00, 3'b000);
    bus.PRDATA = 8'h55;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_still_psel", bus.PSEL, 1'b1);
    end
    tick();
    chk("to_psel", bus.PSEL, 1'b0);
    chk("to_penable", bus.PENABLE, 1'b0);
    chk("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to_rsp_err", bus.rsp_err, 1'b1);
    chk("to_rsp_rdata", bus.rsp_rdata, 8'h00);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    // PREADY arriving on the expiry edge completes normally
    send(32'h0000_0044, 1'b0, 8'h00, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 1; i <= 15; i++) tick();
    chk("to_race_psel", bus.PSEL, 1'b1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h44;
    tick();
    chk("to_race_rsp_err", bus.rsp_err, 1'b0);
    chk("to_race_rsp_rdata", bus.rsp_rdata, 8'h44);
    bus.PREADY = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
`else
    // without the timeout the bridge waits in ACCESS indefinitely
    send(32'h0000_0040, 1'b0, 8'h00, 3'b000);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) tick();
    chk("no_to_psel", bus.PSEL, 1'b1);
    chk("no_to_penable", bus.PENABLE, 1'b1);
    chk("no_to_rsp_valid", bus.rsp_valid, 1'b0);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h66;
    tick();
    chk("no_to_done_rdata", bus.rsp_rdata, 8'h66);
    bus.PREADY = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
